pixel_dispatch: RTL and testbench

//  Frame-level producer/consumer for the renderer pixel stream. Issues raster-order
//  (hcount,vcount) beats on two AXI-stream channels and bounds in-flight pixels with a credit counter.

---
 rtl/pixel_dispatch.sv | 257 +++++++++++++++++++++++++
 tb/tb_pixel_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatch.sv
// ---------------------------------------------------------------------------
// pixel_dispatch
//
// Frame-level producer/consumer for the renderer pixel stream.
//   * Issues raster-order (x,y) coordinate beats on two independent
//     AXI-stream channels (hcount / vcount).
//   * Bounds the number of issued-but-unreturned pixels with a credit counter.
//   * Accepts the returned pixel stream with its echoed coordinates, checks
//     the echo against the expected raster position and writes each pixel
//     to the framebuffer port one cycle after acceptance.
//
// Handshake rule used on every stream port: a transfer happens on a cycle
// where tvalid and tready are both high. A producer never drops tvalid or
// changes tdata while waiting for tready.
//
// Build option:
//   PIXEL_DISPATCH_RGB565_EN  defined   -> fb_data is RGB565 (16 bits,
//                                          truncated from RGB888)
//                             undefined -> fb_data is RGB888 (24 bits)
//
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   start                pulse, starts one frame when idle
//   busy                 high while issuing or draining a frame
//   frame_done           one-cycle pulse after the final framebuffer write
//   err_seq              sticky echo-mismatch / spurious-pixel flag
//   hcount_axis_*        x coordinate stream (out)
//   vcount_axis_*        y coordinate stream (out)
//   pixel_axis_*         returned pixel stream (in), RGB888 {r,g,b}
//   hcount_in, vcount_in coordinates echoed alongside each pixel
//   fb_addr/fb_data/fb_we framebuffer write port
//   state_dbg            current FSM state (0 idle,1 issue,2 drain,3 done)
// ---------------------------------------------------------------------------
module pixel_dispatch #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 180,
    parameter int MAX_INFLIGHT = 512,
    parameter int FB_ADDR_W    = 16,
`ifdef PIXEL_DISPATCH_RGB565_EN
    localparam int FB_DATA_W   = 16
`else
    localparam int FB_DATA_W   = 24
`endif
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_seq,
    output logic [10:0]          hcount_axis_tdata,
    output logic                 hcount_axis_tvalid,
    input  logic                 hcount_axis_tready,
    output logic [9:0]           vcount_axis_tdata,
    output logic                 vcount_axis_tvalid,
    input  logic                 vcount_axis_tready,
    input  logic [23:0]          pixel_axis_tdata,
    input  logic                 pixel_axis_tvalid,
    output logic                 pixel_axis_tready,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [FB_DATA_W-1:0] fb_data,
    output logic                 fb_we,
    output logic [1:0]           state_dbg
);

    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int CNT_W = FB_ADDR_W + 1;

    localparam logic [10:0]      X_LAST = 11'(H_RES - 1);
    localparam logic [9:0]       Y_LAST = 10'(V_RES - 1);
    localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(H_RES * V_RES);
    localparam logic [IF_W:0]    MAX_V  = (IF_W + 1)'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;

    // Per-channel "this channel already handed off the current beat".
    logic h_done;
    logic v_done;

    logic [IF_W-1:0]  inflight;
    logic [CNT_W-1:0] wr_cnt;

    // Raster position expected for the next returned pixel (tracks wr_cnt).
    logic [10:0] exp_x;
    logic [9:0]  exp_y;

    logic           h_fire;
    logic           v_fire;
    logic           beat_done;
    logic           last_beat;
    logic           accept;
    logic           spurious;
    logic           good_accept;
    logic           credit_ok;
    logic           coord_ok;
    logic [IF_W:0]  inflight_next;
    logic [FB_DATA_W-1:0] pix_conv;

    assign busy              = (state == S_ISSUE) || (state == S_DRAIN);
    assign pixel_axis_tready = busy;
    assign state_dbg         = state;

`ifdef PIXEL_DISPATCH_RGB565_EN
    assign pix_conv = {pixel_axis_tdata[23:19], pixel_axis_tdata[15:10], pixel_axis_tdata[7:3]};
`else
    assign pix_conv = pixel_axis_tdata;
`endif

    always_comb begin
        h_fire        = hcount_axis_tvalid && hcount_axis_tready;
        v_fire        = vcount_axis_tvalid && vcount_axis_tready;
        // A beat completes once both channels have handed off, either in
        // this cycle or in an earlier one.
        beat_done     = (state == S_ISSUE) && (h_done || h_fire) && (v_done || v_fire);
        last_beat     = beat_done && (hcount_axis_tdata == X_LAST) && (vcount_axis_tdata == Y_LAST);
        accept        = pixel_axis_tvalid && busy;
        // A pixel with no outstanding credit cannot belong to this frame.
        spurious      = accept && (inflight == '0);
        good_accept   = accept && (inflight != '0);
        inflight_next = {1'b0, inflight} + (IF_W + 1)'(beat_done) - (IF_W + 1)'(good_accept);
        // Valids for the next cycle are raised only if that cycle's count
        // leaves room for one more beat.
        credit_ok     = inflight_next < MAX_V;
        coord_ok      = (hcount_in == exp_x) && (vcount_in == exp_y);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state              <= S_IDLE;
            h_done             <= 1'b0;
            v_done             <= 1'b0;
            hcount_axis_tvalid <= 1'b0;
            vcount_axis_tvalid <= 1'b0;
            hcount_axis_tdata  <= '0;
            vcount_axis_tdata  <= '0;
            inflight           <= '0;
            wr_cnt             <= '0;
            exp_x              <= '0;
            exp_y              <= '0;
            err_seq            <= 1'b0;
            frame_done         <= 1'b0;
            fb_we              <= 1'b0;
            fb_addr            <= '0;
            fb_data            <= '0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;

            // Return path: only active in ISSUE/DRAIN because accept is
            // qualified by busy.
            if (good_accept) begin
                fb_we   <= 1'b1;
                fb_addr <= wr_cnt[FB_ADDR_W-1:0];
                fb_data <= pix_conv;
                wr_cnt  <= wr_cnt + 1'b1;
                if (exp_x == X_LAST) begin
                    exp_x <= '0;
                    exp_y <= exp_y + 1'b1;
                end else begin
                    exp_x <= exp_x + 1'b1;
                end
                if (!coord_ok) begin
                    err_seq <= 1'b1;
                end
            end
            if (spurious) begin
                err_seq <= 1'b1;
            end
            if (busy) begin
                inflight <= inflight_next[IF_W-1:0];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state              <= S_ISSUE;
                        h_done             <= 1'b0;
                        v_done             <= 1'b0;
                        hcount_axis_tdata  <= '0;
                        vcount_axis_tdata  <= '0;
                        inflight           <= '0;
                        wr_cnt             <= '0;
                        exp_x              <= '0;
                        exp_y              <= '0;
                        err_seq            <= 1'b0;
                        // The credit counter is empty at frame start, so
                        // the first beat can be offered immediately.
                        hcount_axis_tvalid <= 1'b1;
                        vcount_axis_tvalid <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    if (beat_done) begin
                        h_done <= 1'b0;
                        v_done <= 1'b0;
                        if (last_beat) begin
                            hcount_axis_tvalid <= 1'b0;
                            vcount_axis_tvalid <= 1'b0;
                            state              <= S_DRAIN;
                        end else begin
                            if (hcount_axis_tdata == X_LAST) begin
                                hcount_axis_tdata <= '0;
                                vcount_axis_tdata <= vcount_axis_tdata + 1'b1;
                            end else begin
                                hcount_axis_tdata <= hcount_axis_tdata + 1'b1;
                            end
                            hcount_axis_tvalid <= credit_ok;
                            vcount_axis_tvalid <= credit_ok;
                        end
                    end else begin
                        // Channels progress independently within a beat.
                        if (h_fire) begin
                            h_done             <= 1'b1;
                            hcount_axis_tvalid <= 1'b0;
                        end else if (!hcount_axis_tvalid && !h_done && credit_ok) begin
                            hcount_axis_tvalid <= 1'b1;
                        end
                        if (v_fire) begin
                            v_done             <= 1'b1;
                            vcount_axis_tvalid <= 1'b0;
                        end else if (!vcount_axis_tvalid && !v_done && credit_ok) begin
                            vcount_axis_tvalid <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    // wr_cnt reaches TOTAL in the cycle the final write is
                    // on the port, so frame_done lands one cycle later.
                    if (wr_cnt == TOTAL) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatch.sv
// ---------------------------------------------------------------------------
// tb_pixel_dispatch
//
// Directed sequence of frames on a small 4x3 raster with 8 credits. The
// reference model works in terms of handshake counts: the n-th coordinate
// handed off on a channel must be raster position n, the number of completed
// beats is the smaller of the two channel counts, credits in use are beats
// minus returned pixels, and every good returned pixel k is written to
// address k one cycle later. Pixel return latency and treadies are random
// in some frames.
// ---------------------------------------------------------------------------
module tb_pixel_dispatch;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int TOTAL = H * V;
    localparam int MAXI  = 8;
    localparam int AW    = 4;
`ifdef PIXEL_DISPATCH_RGB565_EN
    localparam int DW    = 16;
    localparam logic [DW-1:0] RGB_EXP = 16'hFC08;
`else
    localparam int DW    = 24;
    localparam logic [DW-1:0] RGB_EXP = 24'hFF8040;
`endif
    localparam int EW    = AW + DW;

    // clock / reset block
    logic aclk;
    logic areset;
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          start;
    logic          busy;
    logic          frame_done;
    logic          err_seq;
    logic [10:0]   hcount_axis_tdata;
    logic          hcount_axis_tvalid;
    logic          hcount_axis_tready;
    logic [9:0]    vcount_axis_tdata;
    logic          vcount_axis_tvalid;
    logic          vcount_axis_tready;
    logic [23:0]   pixel_axis_tdata;
    logic          pixel_axis_tvalid;
    logic          pixel_axis_tready;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic          fb_we;
    logic [1:0]    state_dbg;

    pixel_dispatch #(
        .H_RES(H), .V_RES(V), .MAX_INFLIGHT(MAXI), .FB_ADDR_W(AW)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start), .busy(busy),
        .frame_done(frame_done), .err_seq(err_seq),
        .hcount_axis_tdata(hcount_axis_tdata), .hcount_axis_tvalid(hcount_axis_tvalid),
        .hcount_axis_tready(hcount_axis_tready),
        .vcount_axis_tdata(vcount_axis_tdata), .vcount_axis_tvalid(vcount_axis_tvalid),
        .vcount_axis_tready(vcount_axis_tready),
        .pixel_axis_tdata(pixel_axis_tdata), .pixel_axis_tvalid(pixel_axis_tvalid),
        .pixel_axis_tready(pixel_axis_tready),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .state_dbg(state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int  cyc = 0;
    bit  active = 0;
    int  h_cnt, v_cnt, beats, returned, frame_no, fd_stage, fd_count, last_rel;
    bit  m_err, fd_seen;
    logic [EW-1:0] exp_q[$];
    int  ret_idx_q[$];
    int  ret_time_q[$];
    int  beat_cyc[$];

    // stimulus knobs
    bit  h_rand = 0, v_rand = 0, spur_req = 0;
    int  v_block = 0, ret_allow = -1, corrupt_idx = -1;
    int  delay_lo = 1, delay_hi = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] conv(input logic [23:0] p);
`ifdef PIXEL_DISPATCH_RGB565_EN
        return {p[23:19], p[15:10], p[7:3]};
`else
        return p;
`endif
    endfunction

    task automatic model_clear();
        h_cnt = 0; v_cnt = 0; beats = 0; returned = 0;
        fd_stage = 0; fd_count = 0; fd_seen = 0; m_err = 0; last_rel = 0;
        exp_q.delete(); ret_idx_q.delete(); ret_time_q.delete(); beat_cyc.delete();
    endtask

    // One clock cycle: capture this cycle's handshakes, advance the clock,
    // update the model, check outputs, then drive the next cycle's inputs.
    task automatic tick();
        logic h_hs, v_hs, p_hs, rst_now, start_now, h_vp, v_vp, exp_fd, ev_h, ev_v;
        logic [10:0] h_d, hx;
        logic [9:0]  v_d, vy;
        logic [23:0] p_d;
        logic [EW-1:0] ent;
        int idx, mn;
        h_hs = hcount_axis_tvalid & hcount_axis_tready;
        v_hs = vcount_axis_tvalid & vcount_axis_tready;
        p_hs = pixel_axis_tvalid & pixel_axis_tready;
        h_vp = hcount_axis_tvalid; v_vp = vcount_axis_tvalid;
        h_d = hcount_axis_tdata; v_d = vcount_axis_tdata;
        p_d = pixel_axis_tdata; hx = hcount_in; vy = vcount_in;
        rst_now = areset; start_now = start;
        @(posedge aclk); #1;
        cyc++;
        if (rst_now) begin
            model_clear(); active = 0;
            chk("rst_hvalid", 32'(hcount_axis_tvalid), 0);
            chk("rst_vvalid", 32'(vcount_axis_tvalid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_tready", 32'(pixel_axis_tready), 0);
            chk("rst_fb_we", 32'(fb_we), 0);
            chk("rst_err", 32'(err_seq), 0);
            chk("rst_done", 32'(frame_done), 0);
            chk("rst_state", 32'(state_dbg), 0);
        end else begin
            if (start_now && !active) begin
                model_clear(); active = 1; frame_no++;
            end
            if (h_vp && !h_hs) begin
                chk("h_hold_valid", 32'(hcount_axis_tvalid), 1);
                chk("h_hold_data", 32'(hcount_axis_tdata), 32'(h_d));
            end
            if (v_vp && !v_hs) begin
                chk("v_hold_valid", 32'(vcount_axis_tvalid), 1);
                chk("v_hold_data", 32'(vcount_axis_tdata), 32'(v_d));
            end
            if (h_hs) begin chk("h_tdata", 32'(h_d), 32'(h_cnt % H)); h_cnt++; end
            if (v_hs) begin chk("v_tdata", 32'(v_d), 32'(v_cnt / H)); v_cnt++; end
            exp_fd = (fd_stage == 1);
            fd_stage = 0;
            // Pixel is judged against credits held before this cycle's beat.
            if (p_hs) begin
                if (beats - returned > 0) begin
                    if (32'(hx) != 32'(returned % H) || 32'(vy) != 32'(returned / H)) m_err = 1;
                    exp_q.push_back({AW'(returned), conv(p_d)});
                    returned++;
                    if (returned == TOTAL) fd_stage = 1;
                end else begin
                    m_err = 1;
                end
            end
            mn = (h_cnt < v_cnt) ? h_cnt : v_cnt;
            if (mn > beats) begin
                ret_idx_q.push_back(beats);
                idx = cyc + $urandom_range(delay_hi, delay_lo);
                if (idx < last_rel) idx = last_rel;
                last_rel = idx;
                ret_time_q.push_back(idx);
                beat_cyc.push_back(cyc);
                beats++;
            end
            if (exp_fd) active = 0;
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    chk("fb_we_unexpected", 1, 0);
                end else begin
                    ent = exp_q.pop_front();
                    chk("fb_addr", 32'(fb_addr), 32'(ent[EW-1:DW]));
                    chk("fb_data", 32'(fb_data), 32'(ent[DW-1:0]));
                    if (frame_no == 2 && ent[EW-1:DW] == '0) chk("rgb_conv", 32'(fb_data), 32'(RGB_EXP));
                end
            end
            chk("fb_latency", exp_q.size(), 0);
            if (frame_done) begin fd_count++; fd_seen = 1; end
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            chk("err_seq", 32'(err_seq), 32'(m_err));
            chk("busy", 32'(busy), 32'(active));
            chk("pixel_tready", 32'(pixel_axis_tready), 32'(active));
            chk("credit_bound", 32'(beats - returned <= MAXI), 1);
            ev_h = active && (h_cnt == beats) && (beats < TOTAL) && (beats - returned < MAXI);
            ev_v = active && (v_cnt == beats) && (beats < TOTAL) && (beats - returned < MAXI);
            chk("h_tvalid", 32'(hcount_axis_tvalid), 32'(ev_h));
            chk("v_tvalid", 32'(vcount_axis_tvalid), 32'(ev_v));
        end
        // driver for the next cycle
        hcount_axis_tready = h_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (v_block > 0) begin
            vcount_axis_tready = 1'b0; v_block--;
        end else begin
            vcount_axis_tready = v_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rst_now) begin
            pixel_axis_tvalid = 1'b0;
        end else if (pixel_axis_tvalid && !p_hs) begin
            pixel_axis_tvalid = 1'b1;
        end else if (spur_req) begin
            spur_req = 0;
            pixel_axis_tvalid = 1'b1; pixel_axis_tdata = 24'h123456;
            hcount_in = '0; vcount_in = '0;
        end else if (ret_idx_q.size() > 0 && ret_allow != 0 && ret_time_q[0] <= cyc) begin
            idx = ret_idx_q.pop_front();
            void'(ret_time_q.pop_front());
            if (ret_allow > 0) ret_allow--;
            pixel_axis_tvalid = 1'b1;
            pixel_axis_tdata = (frame_no == 2 && idx == 0) ? 24'hFF8040 : 24'($urandom);
            hcount_in = (idx == corrupt_idx) ? 11'd2 : 11'(idx % H);
            vcount_in = 10'(idx / H);
        end else begin
            pixel_axis_tvalid = 1'b0;
        end
    endtask

    task automatic start_frame();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic run_frame(input int budget);
        int n;
        n = 0;
        while (!fd_seen && n < budget) begin tick(); n++; end
        chk("frame_timeout", 32'(fd_seen), 1);
        repeat (3) tick();
        chk("frame_done_count", fd_count, 1);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats < target && n < budget) begin tick(); n++; end
        chk("beat_timeout", 32'(beats >= target), 1);
    endtask

    initial begin
        int b0;
        start = 0; areset = 1;
        hcount_axis_tready = 1; vcount_axis_tready = 1;
        pixel_axis_tvalid = 0; pixel_axis_tdata = '0; hcount_in = '0; vcount_in = '0;
        frame_no = 0;
        model_clear();
        repeat (3) tick();
        areset = 0;
        repeat (2) tick();

        // frame 1: full rate, long return latency -> 8 credits issued back to back
        delay_lo = 20; delay_hi = 20;
        start_frame();
        run_frame(400);
        chk("burst_span", beat_cyc[MAXI-1] - beat_cyc[0], MAXI - 1);
        chk("f1_err", 32'(err_seq), 0);

        // frame 2: random treadies and latency, first pixel is FF8040
        h_rand = 1; v_rand = 1; delay_lo = 1; delay_hi = 12;
        start_frame();
        run_frame(600);

        // frame 3: returns stalled -> credits exhausted, then one returned
        h_rand = 0; v_rand = 0; delay_lo = 1; delay_hi = 1; ret_allow = 0;
        start_frame();
        repeat (30) tick();
        chk("stall_beats", beats, MAXI);
        chk("stall_hvalid", 32'(hcount_axis_tvalid), 0);
        chk("stall_vvalid", 32'(vcount_axis_tvalid), 0);
        ret_allow = 1;
        repeat (15) tick();
        chk("one_more_beat", beats, MAXI + 1);
        chk("stall2_hvalid", 32'(hcount_axis_tvalid), 0);
        ret_allow = -1;
        run_frame(400);

        // frame 4: vcount channel held off for 3 cycles at the first beat
        delay_lo = 5; delay_hi = 5; v_block = 3;
        start_frame();
        tick();
        chk("vstall_h_low", 32'(hcount_axis_tvalid), 0);
        chk("vstall_v_high", 32'(vcount_axis_tvalid), 1);
        tick(); tick();
        chk("vstall_x_held", 32'(hcount_axis_tdata), 0);
        chk("vstall_no_beat", beats, 0);
        tick();
        chk("vstall_beat", beats, 1);
        chk("vstall_x_adv", 32'(hcount_axis_tdata), 1);
        run_frame(400);

        // frame 5: echo (2,0) where (1,0) is expected
        corrupt_idx = 1; h_rand = 1; delay_lo = 2; delay_hi = 8;
        start_frame();
        run_frame(600);
        corrupt_idx = -1;
        chk("corrupt_sticky", 32'(err_seq), 1);

        // frame 6: start clears the flag; a pixel with no credit sets it
        spur_req = 1;
        start_frame();
        chk("err_cleared", 32'(err_seq), 0);
        run_frame(600);
        chk("spurious_err", 32'(err_seq), 1);

        // frame 7: reset after 3 beats, then a clean frame from (0,0)
        h_rand = 0; delay_lo = 30; delay_hi = 30;
        start_frame();
        wait_beats(3, 50);
        areset = 1; tick(); areset = 0; tick();
        delay_lo = 1; delay_hi = 10; v_rand = 1;
        start_frame();
        chk("restart_x", 32'(hcount_axis_tdata), 0);
        chk("restart_y", 32'(vcount_axis_tdata), 0);
        run_frame(600);
        chk("restart_err", 32'(err_seq), 0);

        // frames 8-9: random, with a start pulse during ISSUE
        for (int f = 0; f < 2; f++) begin
            h_rand = 1; v_rand = 1; delay_lo = 1; delay_hi = 20;
            start_frame();
            wait_beats(2, 100);
            b0 = frame_no;
            start = 1; tick(); start = 0;
            chk("mid_start_ignored", frame_no, b0);
            run_frame(800);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
